// File: rtl/key_debounce_module_pkg.sv
// Shared definitions for the key debounce block: FSM state encoding and 50 MHz timing defaults.
package key_debounce_module_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_fsm_t;

  // 10 ms debounce window and 1 s long-press threshold at 50 MHz
  localparam int unsigned DEF_T_DEB  = 500_000;
  localparam int unsigned DEF_T_LONG = 50_000_000;

endpackage

// File: rtl/key_debounce_module_sync.sv
// Two-flop synchroniser for an active-low key pin; both flops reset to the released level (1).
module key_sync_module (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/key_debounce_module.sv
// Debounced active-low key: synchroniser, counter-based debounce FSM, press/release/long strobes.
// Long-press detection is built only when KEY_LONG_PRESS_EN is defined; otherwise Key_Long is 0.
module key_debounce_module
  import key_debounce_module_pkg::*;
#(
  parameter int unsigned T_DEB  = DEF_T_DEB,
  parameter int unsigned T_LONG = DEF_T_LONG
) (
  input  logic CLK,
  input  logic RST,
  input  logic Key_In,
  output logic Key_State,
  output logic Key_Down,
  output logic Key_Up,
  output logic Key_Long
);

  localparam int unsigned DW = $clog2(T_DEB);
  localparam logic [DW-1:0] DEB_LAST = DW'(T_DEB - 1);

  if (T_DEB < 2 || T_LONG <= T_DEB) begin : g_param_check
    $error("key_debounce_module: need T_DEB >= 2 and T_LONG > T_DEB");
  end

  logic     s1;
  key_fsm_t state;
  logic [DW-1:0] cnt;

  key_sync_module u_sync (
    .clk (CLK),
    .rst (RST),
    .d   (Key_In),
    .q   (s1)
  );

  // s1 is active-low: 0 means the key reads pressed
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      Key_State <= 1'b0;
      Key_Down  <= 1'b0;
      Key_Up    <= 1'b0;
    end else begin
      Key_Down <= 1'b0;
      Key_Up   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (!s1) begin
            state <= PRESS_WAIT;
            cnt   <= DW'(1);
          end
        end
        PRESS_WAIT: begin
          if (s1) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state     <= PRESSED;
            cnt       <= '0;
            Key_Down  <= 1'b1;
            Key_State <= 1'b1;
          end else begin
            cnt <= cnt + DW'(1);
          end
        end
        PRESSED: begin
          if (s1) begin
            state <= RELEASE_WAIT;
            cnt   <= DW'(1);
          end
        end
        RELEASE_WAIT: begin
          if (!s1) begin
            state <= PRESSED;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state     <= IDLE;
            cnt       <= '0;
            Key_Up    <= 1'b1;
            Key_State <= 1'b0;
          end else begin
            cnt <= cnt + DW'(1);
          end
        end
      endcase
    end
  end

`ifdef KEY_LONG_PRESS_EN
  localparam int unsigned LW = $clog2(T_LONG);
  localparam logic [LW-1:0] LONG_LAST = LW'(T_LONG - 1);

  logic [LW-1:0] lcnt;
  logic          long_done;
  logic          held;
  logic          release_accept;

  assign held           = (state == PRESSED) || (state == RELEASE_WAIT);
  assign release_accept = (state == RELEASE_WAIT) && s1 && (cnt == DEB_LAST);

  // Counter restarts while not held, so it is always fresh on the edge after Key_Down.
  // The release-accept edge is excluded so Key_Long never coincides with Key_Up.
  always_ff @(posedge CLK) begin
    if (RST) begin
      lcnt      <= '0;
      long_done <= 1'b0;
      Key_Long  <= 1'b0;
    end else begin
      Key_Long <= 1'b0;
      if (!held) begin
        lcnt      <= '0;
        long_done <= 1'b0;
      end else if (!long_done && !release_accept) begin
        if (lcnt == LONG_LAST) begin
          Key_Long  <= 1'b1;
          long_done <= 1'b1;
        end else begin
          lcnt <= lcnt + LW'(1);
        end
      end
    end
  end
`else
  assign Key_Long = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce_module.sv
// Bench for key_debounce_module: directed scenarios plus random bounce, checked against a run-length model.
module tb_key_debounce_module;

  localparam int unsigned T_DEB  = 4;
  localparam int unsigned T_LONG = 20;
`ifdef KEY_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
`else
  localparam bit LONG_EN = 1'b0;
`endif

  logic clk, rst, key_in;
  logic key_state, key_down, key_up, key_long;

  int total  = 0;
  int passed = 0;

  key_debounce_module #(.T_DEB(T_DEB), .T_LONG(T_LONG)) dut (
    .CLK       (clk),
    .RST       (rst),
    .Key_In    (key_in),
    .Key_State (key_state),
    .Key_Down  (key_down),
    .Key_Up    (key_up),
    .Key_Long  (key_long)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the pin reaches the filter two edges late; the accepted level flips
  // after T_DEB consecutive samples disagreeing with it; long fires on the T_LONG-th held edge.
  logic [1:0]  m_pipe = 2'b11;
  bit          m_lvl, m_fired;
  int unsigned m_run, m_held;
  bit          e_state, e_down, e_up, e_long;

  always @(posedge clk) begin : model_blk
    bit          pressed_sample, lvl_n, fired_n, dn, up, lg;
    int unsigned run_n, held_n;
    if (rst) begin
      m_pipe  <= 2'b11;
      m_lvl   <= 1'b0;
      m_run   <= 0;
      m_held  <= 0;
      m_fired <= 1'b0;
      e_state <= 1'b0;
      e_down  <= 1'b0;
      e_up    <= 1'b0;
      e_long  <= 1'b0;
    end else begin
      pressed_sample = !m_pipe[1];
      lvl_n   = m_lvl;
      fired_n = m_fired;
      held_n  = m_held;
      dn = 1'b0; up = 1'b0; lg = 1'b0;
      run_n = (pressed_sample != m_lvl) ? m_run + 1 : 0;
      if (run_n == T_DEB) begin
        lvl_n = !m_lvl;
        run_n = 0;
        if (lvl_n) begin
          dn = 1'b1; held_n = 0; fired_n = 1'b0;
        end else begin
          up = 1'b1;
        end
      end else if (m_lvl) begin
        held_n = m_held + 1;
        if (LONG_EN && held_n == T_LONG && !fired_n) begin
          lg = 1'b1; fired_n = 1'b1;
        end
      end
      m_pipe  <= {m_pipe[0], key_in};
      m_lvl   <= lvl_n;
      m_run   <= run_n;
      m_held  <= held_n;
      m_fired <= fired_n;
      e_state <= lvl_n;
      e_down  <= dn;
      e_up    <= up;
      e_long  <= lg;
    end
  end

  task automatic drive_cycle(input logic k);
    key_in = k;
    @(negedge clk);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if ({key_state, key_down, key_up, key_long} !== 4'b0000)
        $display("FAIL reset_outputs cyc=%0d got=%b want=0000", i, {key_state, key_down, key_up, key_long});
      else passed++;
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1);
      total++;
      if ({key_state, key_down, key_up, key_long} !== {e_state, e_down, e_up, e_long})
        $display("FAIL reset_idle cyc=%0d got=%b want=%b", i, {key_state, key_down, key_up, key_long}, {e_state, e_down, e_up, e_long});
      else passed++;
    end
  endtask

  task automatic test_clean_press();
    int down_at = -1, downs = 0, up_at = -1, ups = 0;
    for (int i = 1; i <= 10; i++) begin
      drive_cycle(1'b0);
      if (key_down) begin downs++; down_at = i; end
      total++;
      if ({key_state, key_down, key_up, key_long} !== {e_state, e_down, e_up, e_long})
        $display("FAIL press_model cyc=%0d got=%b want=%b", i, {key_state, key_down, key_up, key_long}, {e_state, e_down, e_up, e_long});
      else passed++;
    end
    total++;
    if (down_at != int'(T_DEB) + 2 || downs != 1)
      $display("FAIL press_latency got cyc=%0d count=%0d want cyc=%0d count=1", down_at, downs, T_DEB + 2);
    else passed++;
    total++;
    if (key_state !== 1'b1) $display("FAIL press_level got=%b want=1", key_state);
    else passed++;
    for (int i = 1; i <= 12; i++) begin
      drive_cycle(1'b1);
      if (key_up) begin ups++; up_at = i; end
      total++;
      if ({key_state, key_down, key_up, key_long} !== {e_state, e_down, e_up, e_long})
        $display("FAIL release_model cyc=%0d got=%b want=%b", i, {key_state, key_down, key_up, key_long}, {e_state, e_down, e_up, e_long});
      else passed++;
    end
    total++;
    if (up_at != int'(T_DEB) + 2 || ups != 1)
      $display("FAIL release_latency got cyc=%0d count=%0d want cyc=%0d count=1", up_at, ups, T_DEB + 2);
    else passed++;
  endtask

  task automatic test_glitch();
    int downs = 0;
    for (int i = 1; i <= 15; i++) begin
      drive_cycle(i <= 3 ? 1'b0 : 1'b1);
      if (key_down) downs++;
      total++;
      if ({key_state, key_down, key_up, key_long} !== {e_state, e_down, e_up, e_long})
        $display("FAIL glitch_model cyc=%0d got=%b want=%b", i, {key_state, key_down, key_up, key_long}, {e_state, e_down, e_up, e_long});
      else passed++;
    end
    total++;
    if (downs != 0 || key_state !== 1'b0)
      $display("FAIL glitch_reject got downs=%0d level=%b want downs=0 level=0", downs, key_state);
    else passed++;
  endtask

  task automatic test_long_press();
    int down_at = -1, long_at = -1, longs = 0;
    for (int i = 1; i <= int'(T_DEB) + 2 + 30; i++) begin
      drive_cycle(1'b0);
      if (key_down) down_at = i;
      if (key_long) begin longs++; long_at = i; end
      total++;
      if ({key_state, key_down, key_up, key_long} !== {e_state, e_down, e_up, e_long})
        $display("FAIL long_model cyc=%0d got=%b want=%b", i, {key_state, key_down, key_up, key_long}, {e_state, e_down, e_up, e_long});
      else passed++;
    end
    total++;
    if (down_at != int'(T_DEB) + 2)
      $display("FAIL long_down_after_glitch got cyc=%0d want cyc=%0d", down_at, T_DEB + 2);
    else passed++;
    total++;
    if (LONG_EN) begin
      if (longs != 1 || long_at - down_at != int'(T_LONG))
        $display("FAIL long_strobe got count=%0d offset=%0d want count=1 offset=%0d", longs, long_at - down_at, T_LONG);
      else passed++;
    end else begin
      if (longs != 0)
        $display("FAIL long_disabled got count=%0d want count=0", longs);
      else passed++;
    end
  endtask

  task automatic test_release_bounce();
    int up_at = -1, ups = 0, early_drop = 0;
    logic pat [3];
    pat[0] = 1'b1; pat[1] = 1'b1; pat[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(pat[i]);
      if (key_state !== 1'b1 || key_up) early_drop++;
      total++;
      if ({key_state, key_down, key_up, key_long} !== {e_state, e_down, e_up, e_long})
        $display("FAIL bounce_model cyc=%0d got=%b want=%b", i, {key_state, key_down, key_up, key_long}, {e_state, e_down, e_up, e_long});
      else passed++;
    end
    for (int i = 1; i <= 12; i++) begin
      drive_cycle(1'b1);
      if (key_up) begin ups++; up_at = i; end
      if (up_at < 0 && key_state !== 1'b1) early_drop++;
      total++;
      if ({key_state, key_down, key_up, key_long} !== {e_state, e_down, e_up, e_long})
        $display("FAIL bounce_model cyc=%0d got=%b want=%b", i + 3, {key_state, key_down, key_up, key_long}, {e_state, e_down, e_up, e_long});
      else passed++;
    end
    total++;
    if (up_at != int'(T_DEB) + 2 || ups != 1 || early_drop != 0)
      $display("FAIL bounce_release got cyc=%0d count=%0d early=%0d want cyc=%0d count=1 early=0", up_at, ups, early_drop, T_DEB + 2);
    else passed++;
  endtask

  task automatic test_reset_mid_press();
    int down_at = -1, downs = 0;
    for (int i = 0; i < 3; i++) drive_cycle(1'b0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b0);
      total++;
      if ({key_state, key_down, key_up, key_long} !== 4'b0000)
        $display("FAIL midreset_outputs cyc=%0d got=%b want=0000", i, {key_state, key_down, key_up, key_long});
      else passed++;
    end
    rst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      drive_cycle(1'b0);
      if (key_down) begin downs++; down_at = i; end
      total++;
      if ({key_state, key_down, key_up, key_long} !== {e_state, e_down, e_up, e_long})
        $display("FAIL midreset_model cyc=%0d got=%b want=%b", i, {key_state, key_down, key_up, key_long}, {e_state, e_down, e_up, e_long});
      else passed++;
    end
    total++;
    if (down_at != int'(T_DEB) + 2 || downs != 1)
      $display("FAIL midreset_down got cyc=%0d count=%0d want cyc=%0d count=1", down_at, downs, T_DEB + 2);
    else passed++;
    for (int i = 0; i < 12; i++) drive_cycle(1'b1);
    total++;
    if (key_state !== 1'b0) $display("FAIL midreset_released got=%b want=0", key_state);
    else passed++;
  endtask

  task automatic test_random_bounce();
    logic k = 1'b1;
    int   run_left = 0, downs = 0;
    bit   last_down = 1'b0, prev_d = 1'b0, prev_u = 1'b0, prev_l = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      if (run_left == 0) begin
        k = ~k;
        run_left = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 40)) : int'($urandom_range(1, 7));
      end
      run_left--;
      drive_cycle(k);
      total++;
      if ({key_state, key_down, key_up, key_long} !== {e_state, e_down, e_up, e_long})
        $display("FAIL random_model cyc=%0d got=%b want=%b", i, {key_state, key_down, key_up, key_long}, {e_state, e_down, e_up, e_long});
      else passed++;
      total++;
      if (int'(key_down) + int'(key_up) + int'(key_long) > 1)
        $display("FAIL random_exclusive cyc=%0d got=%b want at most one strobe", i, {key_down, key_up, key_long});
      else passed++;
      total++;
      if ((prev_d && key_down) || (prev_u && key_up) || (prev_l && key_long))
        $display("FAIL random_width cyc=%0d got=%b prev=%b want single-cycle strobes", i, {key_down, key_up, key_long}, {prev_d, prev_u, prev_l});
      else passed++;
      if (key_down || key_up) begin
        total++;
        if (key_down == last_down)
          $display("FAIL random_alternate cyc=%0d got down=%b after down=%b want alternation", i, key_down, last_down);
        else passed++;
        last_down = key_down;
        if (key_down) downs++;
      end
      prev_d = key_down; prev_u = key_up; prev_l = key_long;
    end
    total++;
    if (downs == 0) $display("FAIL random_activity got downs=0 want >0");
    else passed++;
  endtask

  initial begin
    rst    = 1'b1;
    key_in = 1'b1;
    test_reset();
    test_clean_press();
    test_glitch();
    test_long_press();
    test_release_bounce();
    test_reset_mid_press();
    test_random_bounce();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
